mul_iter32: RTL and testbench
=============================

// Module: mul_iter32
// PURPOSE
//  Iterative 32x32->64 shift-add multiplier for the multi-cycle datapath.
//  Sits upstream of the 32-bit 2:1 write-back select muxes: prod_lo/prod_hi
//  feed the mux data inputs, and the controller waits on done before selecting them.
//  One partial-product step per clock; start/busy/done handshake to the controller FSM.
// PARAMETERS
//  WIDTH   32  operand width; product is 2*WIDTH. Only 32 is verified.
//  CNT_W   6   iteration counter width; must satisfy 2^CNT_W > WIDTH.
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst_n      in   1   synchronous active-low reset
//  start      in   1   request; accepted only in IDLE or DONE
//  op_a       in   32  multiplicand, sampled on the accepting edge
//  op_b       in   32  multiplier, sampled on the accepting edge
//  is_signed  in   1   signed-operand request, sampled with operands
//  busy       out  1   high while in CALC
//  done       out  1   one-cycle pulse; product valid from this cycle onward
//  prod_hi    out  32  product bits [63:32]
//  prod_lo    out  32  product bits [31:0]
// BEHAVIOUR
//  Reset: synchronous active-low. On the edge where rst_n=0: state=IDLE, busy=0,
//   done=0, prod_hi=prod_lo=0, counter=0. Takes priority over every other input,
//   including mid-CALC. The operation in progress is discarded and no done is issued.
//  FSM: IDLE -(start)-> CALC -(cnt==WIDTH-1)-> DONE -(start)-> CALC, else -> IDLE.
//  Accept: on an edge in IDLE or DONE with start=1, latch op_a/op_b/is_signed.
//   Clear the accumulator, set cnt=0, and enter CALC.
//  CALC: each cycle, if multiplier LSB=1 add the multiplicand into the upper half.
//   Then shift the {carry,acc,multiplier} register right by 1 and increment cnt.
//   The 33-bit add keeps its carry; no bit is lost.
//  Latency: start seen on edge T -> busy=1 for cycles T+1..T+32.
//   done=1 in cycle T+33 only. Total latency is 33 clocks, independent of operand values.
//  prod_hi/prod_lo: updated only on entry to DONE.
//   Held stable until the next DONE or reset; they are not intermediate values.
//  start while busy=1: ignored. No queueing, no error flag. Current op unaffected.
//  start in the DONE cycle: accepted; back-to-back ops with 33-cycle spacing.
//  Operand changes after the accepting edge have no effect.
//  Zero operand: still takes the full 33 cycles; no early termination.
// CONFIGURATION
//  SIGNED_MUL_EN defined:
//   - If latched is_signed=1: multiply the two's-complement magnitudes of op_a/op_b.
//   - If the operand signs differ, negate the 64-bit result on the DONE-entry edge.
//   - Latency is unchanged. -2^31 * -2^31 = 0x40000000_00000000.
//  SIGNED_MUL_EN undefined:
//   - is_signed is ignored and all operands are treated as unsigned.
//   - No magnitude or negation logic is generated; the port remains present.
// TESTING
//  1. rst_n=0 two cycles, release, then start with 3*5 -> busy cycles 1-32.
//     done at +33; prod_hi=0, prod_lo=0x0000000F.
//  2. 0xFFFFFFFF*0xFFFFFFFF unsigned -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
//  3. is_signed=1, op_a=0xFFFFFFFE (-2), op_b=3:
//     - with SIGNED_MUL_EN: prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFFA.
//     - without it: prod_hi=0x00000002, prod_lo=0xFFFFFFFA.
//  4. Start 7*9, pulse start with 1*1 at busy cycle 5, and change op_a mid-CALC:
//     - exactly one done, at +33, with prod_lo=0x3F;
//     - no second done.
//  5. Start 0x12345678*0x10, drive rst_n=0 at busy cycle 10:
//     - next cycle busy=0, done=0, prod=0, and no done follows;
//     - a fresh 2*2 then completes with prod_lo=4.
//  6. Start A=6*7; in its done cycle start B=0*0xFFFFFFFF:
//     - A gives prod_lo=42 at done;
//     - B's done comes 33 cycles later with prod=0, and A's result is held in between.

Source files
------------

// File: rtl/mul_iter32.sv
// mul_iter32: iterative 32x32->64 shift-add multiplier with start/busy/done handshake.
// Optional feature macro SIGNED_MUL_EN: when defined, the latched is_signed selects
// a signed multiply (magnitudes multiplied, result negated on sign mismatch).
module mul_iter32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] fin;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               accept, last;

`ifdef SIGNED_MUL_EN
    logic neg_q, neg_d;
    logic a_neg, b_neg;
    assign a_neg = is_signed & op_a[WIDTH-1];
    assign b_neg = is_signed & op_b[WIDTH-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;
    assign neg_d = accept ? (a_neg ^ b_neg) : neg_q;
    assign fin   = neg_q ? -step : step;

    // Sign of the result, captured with the operands.
    always_ff @(posedge clk) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign mag_a = op_a;
    assign mag_b = op_b;
    assign fin   = step;
`endif

    assign busy    = state_q == S_CALC;
    assign done    = state_q == S_DONE;
    assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
    assign prod_lo = prod_q[WIDTH-1:0];

    // Next state: accept in IDLE/DONE, one add-and-shift per CALC cycle, publish on DONE entry.
    always_comb begin
        accept  = start && (state_q != S_CALC);
        last    = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH-1));
        sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        step    = {sum, mplr_q[WIDTH-1:1]};
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = mag_a;
            mplr_d  = mag_b;
        end else if (state_q == S_CALC) begin
            acc_d   = step[2*WIDTH-1:WIDTH];
            mplr_d  = step[WIDTH-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = last ? S_DONE : S_CALC;
            prod_d  = last ? fin : prod_q;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: tb/tb_mul_iter32.sv
// tb_mul_iter32: randomized self-checking bench for mul_iter32 against an arithmetic model.
module tb_mul_iter32;
`ifdef SIGNED_MUL_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        is_signed = 1'b0;
    logic        busy, done;
    logic [31:0] prod_hi, prod_lo;
    logic [63:0] last = '0;
    int          checks = 0;
    int          errors = 0;

    mul_iter32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .is_signed(is_signed), .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (s && SIGNED_EN) return sa * sb;
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; start is raised now and accepted on the next posedge.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s, input int pulse_at);
        logic [63:0] exp;
        exp = model(a, b, s);
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
            start = (i == pulse_at);
            if (i == pulse_at) begin op_a = 32'd1; op_b = 32'd1; end
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("held", {prod_hi, prod_lo}, last);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_end", busy, 0);
        check("done", done, 1);
        check("prod", {prod_hi, prod_lo}, exp);
        last = exp;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_prod", {prod_hi, prod_lo}, last);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_prod", {prod_hi, prod_lo}, 0);
        rst_n = 1'b1;
        op(32'd3, 32'd5, 1'b0, 0);
        check("t1_lo", {32'd0, prod_lo}, 64'h0000000F);
        idle(3);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        check("t2", {prod_hi, prod_lo}, SIGNED_EN ? 64'hFFFFFFFE_00000001 : 64'hFFFFFFFE_00000001);
        idle(1);
        op(32'hFFFFFFFE, 32'd3, 1'b1, 0);
        check("t3", {prod_hi, prod_lo}, SIGNED_EN ? 64'hFFFFFFFF_FFFFFFFA : 64'h00000002_FFFFFFFA);
        idle(1);
        op(32'h80000000, 32'h80000000, 1'b1, 0);
        check("min_sq", {prod_hi, prod_lo}, SIGNED_EN ? 64'h40000000_00000000 : 64'h40000000_00000000);
        idle(2);
        op(32'd7, 32'd9, 1'b0, 5);
        check("t4_lo", {32'd0, prod_lo}, 64'h3F);
        idle(40);
        start = 1'b1; op_a = 32'h12345678; op_b = 32'h10; is_signed = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("t5_busy", busy, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_prod", {prod_hi, prod_lo}, 0);
        rst_n = 1'b1;
        last = '0;
        idle(40);
        op(32'd2, 32'd2, 1'b0, 0);
        check("t5_lo", {32'd0, prod_lo}, 64'd4);
        idle(1);
        op(32'd6, 32'd7, 1'b0, 0);
        check("t6_a", {32'd0, prod_lo}, 64'd42);
        op(32'd0, 32'hFFFFFFFF, 1'b0, 0);
        check("t6_b", {prod_hi, prod_lo}, 0);
        idle(2);
        for (int k = 0; k < 20; k++) begin
            op($urandom, $urandom, 1'($urandom), 0);
            if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 0));
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
